// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared widths, op/state enums and operand record for shift_arbiter
package shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_RSVD = 2'b10,
    OP_SRA  = 2'b11
  } shift_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [SHAMT_W-1:0] amt;
    shift_op_e          op;
    logic               id;
  } operand_t;

endpackage

// File: rtl/shifter_32_bit_lr.sv
// rtl/shifter_32_bit_lr.sv - combinational 32-bit left/right logical/arithmetic shifter
module shifter_32_bit_lr
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_amt,
  input  shift_op_e          i_op,
  output logic [DATA_W-1:0]  o_result
);

  always_comb begin
    o_result = i_data;
    case (i_op)
      OP_SLL:  o_result = i_data << i_amt;
      OP_SRL:  o_result = i_data >> i_amt;
      OP_SRA:  o_result = DATA_W'($signed(i_data) >>> i_amt);
      default: o_result = i_data;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin sharing of one shifter between two valid/ready requesters
module shift_arbiter
  import shift_pkg::*;
#(
  parameter logic RR_INIT = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req0_valid,
  output logic               o_req0_ready,
  input  logic [DATA_W-1:0]  i_req0_data,
  input  logic [SHAMT_W-1:0] i_req0_amt,
  input  logic [1:0]         i_req0_op,
  input  logic               i_req1_valid,
  output logic               o_req1_ready,
  input  logic [DATA_W-1:0]  i_req1_data,
  input  logic [SHAMT_W-1:0] i_req1_amt,
  input  logic [1:0]         i_req1_op,
  output logic               o_rsp_valid,
  output logic [DATA_W-1:0]  o_rsp_data,
  output logic               o_rsp_id,
  output logic               o_busy
);

  arb_state_e        state_q, state_d;
  logic              ptr_q, ptr_d;
  operand_t          opnd_q, opnd_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_id_q, rsp_id_d;

  logic              grant0, grant1, hs;
  logic [DATA_W-1:0] shift_res;

  // ptr_q holds the last granted port; under contention the other one wins
  assign grant0 = i_req0_valid && (!i_req1_valid || ptr_q);
  assign grant1 = i_req1_valid && (!i_req0_valid || !ptr_q);

  assign o_req0_ready = (state_q == IDLE) && grant0;
  assign o_req1_ready = (state_q == IDLE) && grant1;
  assign hs           = o_req0_ready || o_req1_ready;

  shifter_32_bit_lr u_shifter (
    .i_data   (opnd_q.data),
    .i_amt    (opnd_q.amt),
    .i_op     (opnd_q.op),
    .o_result (shift_res)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    opnd_d      = opnd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = EXEC;
          ptr_d   = grant1;
          if (grant1) begin
            opnd_d = '{data: i_req1_data, amt: i_req1_amt, op: shift_op_e'(i_req1_op), id: 1'b1};
          end else begin
            opnd_d = '{data: i_req0_data, amt: i_req0_amt, op: shift_op_e'(i_req0_op), id: 1'b0};
          end
        end
      end
      EXEC: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = shift_res;
        rsp_id_d    = opnd_q.id;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= RR_INIT;
      opnd_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      opnd_q      <= opnd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_busy      = (state_q == EXEC);

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one combinational 32-bit shift datapath between two requesters: port 0 is the ALU shift path and port 1 is the load/store byte-alignment path. Each port uses a valid/ready request handshake. A round-robin grant picks one request, the block latches its operands, and it returns one registered result tagged with the requester ID. The block sits beside the execute stage. It lets both consumers use a single shifter instead of instantiating two.

## Interface
- `RR_INIT` (default 1'b1): value of the last-grant pointer at reset. With 1, port 0 wins the first contention.
- `i_clk` (input, 1): clock. Every register updates on the rising edge.
- `i_rst_n` (input, 1): asynchronous, active-low reset.
- `i_req0_valid` (input, 1): port 0 has a request pending.
- `o_req0_ready` (output, 1): port 0 request is accepted this cycle.
- `i_req0_data` (input, 32): port 0 operand.
- `i_req0_amt` (input, 5): port 0 shift amount.
- `i_req0_op` (input, 2): port 0 operation.
- `i_req1_valid`, `o_req1_ready`, `i_req1_data`, `i_req1_amt`, `i_req1_op`: same as port 0, for port 1.
- `o_rsp_valid` (output, 1): one-cycle pulse marking a valid result.
- `o_rsp_data` (output, 32): shifted result.
- `o_rsp_id` (output, 1): requester that issued the result.
- `o_busy` (output, 1): high while the state is EXEC.

## Operation
- Op encoding:
  - 2'b00: SLL.
  - 2'b01: SRL (zero fill).
  - 2'b11: SRA (fills with bit 31 of the operand).
  - 2'b10: reserved. The result is the operand unchanged.
- Shift amounts 0 to 31 are all legal. Amount 0 returns the operand unchanged for every op.
- FSM states and transitions:
  - IDLE: the block may accept a request.
  - IDLE → EXEC on any handshake (valid && ready).
  - EXEC → IDLE unconditionally after one cycle.
- Grant rule in IDLE:
  - Only one port valid: that port is granted.
  - Both ports valid: grant the port that is not the last-grant pointer.
  - The pointer updates only on a handshake.
- `o_reqN_ready` = (state == IDLE) && grantN. It is combinational from valid and state.
- Requesters must not make valid depend on ready.
- Once valid is asserted, the requester holds valid, data, amt and op stable until ready.
- On handshake:
  - Operands, op and ID are latched into the operand register.
  - In EXEC the shifter works on the latched operands.
  - The result, the ID and `o_rsp_valid`=1 are registered at the end of EXEC.
- `o_rsp_valid` drops the following cycle unless another result completes.
- `o_rsp_data` and `o_rsp_id` hold their last values while `o_rsp_valid` is 0.
- Responses have no backpressure. Consumers must take the result in the cycle `o_rsp_valid` is high.
- Reset values:
  - `o_rsp_valid`, `o_rsp_data`, `o_rsp_id`, `o_busy`: 0.
  - State: IDLE.
  - Operand register: 0.
  - Pointer: `RR_INIT`.
- Reset during EXEC aborts the in-flight request. No response is produced. The requester must re-issue.

## Timing
- Handshake at edge T.
- EXEC spans cycle T+1.
- `o_rsp_valid` is high in cycle T+2.
- Latency is 2 cycles from acceptance to response.
- Peak throughput is one request per 2 cycles.
- A new handshake may occur in the same cycle that `o_rsp_valid` is high (state is back in IDLE).
- `o_busy` is high exactly in the EXEC cycle. Both readys are 0 during that cycle.
- A single continuously valid port is granted every IDLE cycle. No idle cycles are forced for fairness.
- Asserting reset forces every output to its reset value immediately, without waiting for a clock edge.

## Structure
- Package `shift_pkg` holds:
  - `DATA_W`=32.
  - `SHAMT_W`=5.
  - `shift_op_e` enum (SLL, SRL, SRA, RSVD).
  - `arb_state_e` enum (IDLE, EXEC).
- Sub-module `shifter_32_bit_lr` is purely combinational.
  - Inputs: data, amt, op.
  - Output: result.
  - Instantiated once, on the latched operands.
- Arbiter, FSM and output register live in `shift_arbiter`.

## Test plan
- **Basic SLL timing.** Reset, then port 0 requests SLL of 0x0000_0001 by 31. Expected: handshake, then two cycles later `o_rsp_valid`=1, data 0x8000_0000, id 0, `o_busy` high in between.
- **Right shifts on port 1.** Port 1 SRA 0x8000_0000 by 4 returns 0xF800_0000 with id 1. SRL of the same operand by 4 returns 0x0800_0000.
- **Round-robin under contention.** Both ports valid continuously with `RR_INIT`=1. Grants go 0,1,0,1 with one handshake every 2 cycles, and each response ID matches its grant.
- **Pass-through cases.** Amount 0 with op SRA returns 0xDEAD_BEEF unchanged. Op 2'b10 with amount 7 also returns 0xDEAD_BEEF unchanged.
- **Reset mid-operation.** Assert `i_rst_n` low during EXEC. Expected: outputs go to 0 asynchronously, no `o_rsp_valid` ever appears for the aborted request, and after release the first contended grant goes to port 0.
- **Single busy port.** Port 1 alone stays valid with port 0 idle. Expected: port 1 is accepted every IDLE cycle, a handshake and the previous `o_rsp_valid` coincide, and consecutive results come back in order.
